wb_commit_queue: RTL and testbench
==================================

// Module: wb_commit_queue
// PURPOSE
//  Parametrised successor to the single-register writeback stage. Buffers up to DEPTH
//  MEM-stage results in order and retires one per cycle into a regfile write port that
//  may be busy (rf_ready low, port shared with a multicycle unit).
//  Raises exception/eret flush when the faulting entry reaches the head.
//  Provides NUM_RD forwarding/stall lookup ports to ID over all buffered entries.
// PARAMETERS
//  DATA_W   32  result / PC width
//  ADDR_W    5  regfile address width
//  BE_W      4  byte write-enable width (DATA_W/8)
//  DEPTH     4  queue entries (power of 2, >=2)
//  NUM_RD    2  ID lookup ports
// PORTS
//  clk            in   1               clock, rising edge
//  resetn         in   1               asynchronous reset, active low
//  flush          in   1               pipeline flush; clears queue
//  ms_to_ws_valid in   1               MEM result valid
//  ws_allowin     out  1               entry accepted this cycle if valid
//  in_pc          in   DATA_W          instruction PC
//  in_dest        in   ADDR_W          destination register
//  in_we          in   BE_W            byte write enables (0 = no writeback)
//  in_wdata       in   DATA_W          result
//  in_exc         in   1               exception pending
//  in_eret        in   1               eret
//  rf_ready       in   1               regfile write port free this cycle
//  rf_we          out  BE_W            regfile byte enables
//  rf_waddr       out  ADDR_W          regfile address
//  rf_wdata       out  DATA_W          regfile data
//  send_flush     out  1               one-cycle pulse: head is exc/eret, retiring
//  exc_eret       out  2               {exc,eret} of retiring head, qualified by send_flush
//  flush_pc       out  DATA_W          PC of retiring exc/eret entry
//  q_raddr        in   NUM_RD*ADDR_W   lookup addresses, port i at [i*ADDR_W +: ADDR_W]
//  q_hit          out  NUM_RD          youngest match found
//  q_data         out  NUM_RD*DATA_W   youngest matching entry's data
//  q_stall        out  NUM_RD          match is partial-byte write or an exc entry
//  debug_wb_pc    out  DATA_W          PC of retiring entry
// BEHAVIOUR
//  - Circular buffer: head/tail pointers plus count (ADDR of $clog2(DEPTH)+1 bits); pointers wrap modulo DEPTH.
//  - Reset (resetn=0, async): count=0, pointers=0; rf_we=0, send_flush=0, exc_eret=0,
//    q_hit=0, q_stall=0, ws_allowin=1; data outputs don't-care (driven 0).
//  - pop (combinational) = head valid && (head.exc || head.eret || head.we==0 || rf_ready).
//  - rf_we = head.we when head valid, no exc/eret, rf_ready, else 0. addr/data from head.
//  - Exc/eret head: send_flush=1, exc_eret set, flush_pc=head.pc, rf_we=0; at the edge the
//    whole queue clears (including same-cycle push). Exc entry never writes the regfile.
//  - ws_allowin = (count<DEPTH) || pop; full queue with pop accepts push same edge.
//  - push = ms_to_ws_valid && ws_allowin && !flush && !send_flush.
//  - flush=1: queue empty at next edge; overrides push and pop; rf_we for the current
//    head still fires in that cycle.
//  - Latency: push at edge N, earliest regfile write in cycle N+1 (visible at edge N+1).
//  - Lookup: among valid entries with we!=0 and dest==q_raddr, q_raddr!=0, pick youngest;
//    q_hit=1, q_data=its wdata; q_stall=1 if its we!=all-ones or it has exc. Addr 0: no hit.
//  - rf_ready low holds head indefinitely; queue fills; ws_allowin drops at count==DEPTH.
// CONFIGURATION
//  WB_BYPASS_EN defined: when queue empty, rf_ready=1, input valid, no exc/eret, no
//    flush, the input drives rf_we/waddr/wdata combinationally and is not enqueued
//    (zero-latency writeback). Lookup ports also see the bypassing input.
//  Not defined: every result is enqueued; minimum one-cycle latency as above.
// TESTING
//  - Reset mid-stream: 3 entries queued, resetn low -> count 0, rf_we=0, ws_allowin=1 at once.
//  - Backpressure: rf_ready=0, push 5 entries (DEPTH=4) -> ws_allowin=0 after 4th; rf_ready=1
//    -> writes r1..r4 in order, one per cycle, then 5th.
//  - Exception: push r2=0x11, exc entry pc=0xBFC0_0100, r3=0x33 -> r2 written, then
//    send_flush=1 with flush_pc=0xBFC0_0100, exc_eret=2'b10, r3 never written.
//  - Forwarding: queue r5=0xAAAA_0001 (we=F) then r5=0x0000_00BB (we=1) ->
//    q_hit=1, q_data=0x0000_00BB, q_stall=1; q_raddr=0 -> q_hit=0.
//  - Flush with simultaneous push on full queue -> empty next cycle, pushed entry dropped.
//  - WB_BYPASS_EN: empty queue, push r7=0x7 with rf_ready=1 -> rf_we=F same cycle, count stays 0.

Source files
------------

// File: rtl/wb_commit_queue_if.sv
// Writeback commit queue bundle: MEM-side input, regfile write port, flush outputs, ID lookups.
// master drives results and lookup addresses; slave is the commit queue.
interface wb_commit_queue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BE_W   = 4,
  parameter int unsigned NUM_RD = 2
) ();
  logic                     flush;
  logic                     ms_to_ws_valid;
  logic                     ws_allowin;
  logic [DATA_W-1:0]        in_pc;
  logic [ADDR_W-1:0]        in_dest;
  logic [BE_W-1:0]          in_we;
  logic [DATA_W-1:0]        in_wdata;
  logic                     in_exc;
  logic                     in_eret;
  logic                     rf_ready;
  logic [BE_W-1:0]          rf_we;
  logic [ADDR_W-1:0]        rf_waddr;
  logic [DATA_W-1:0]        rf_wdata;
  logic                     send_flush;
  logic [1:0]               exc_eret;
  logic [DATA_W-1:0]        flush_pc;
  logic [NUM_RD*ADDR_W-1:0] q_raddr;
  logic [NUM_RD-1:0]        q_hit;
  logic [NUM_RD*DATA_W-1:0] q_data;
  logic [NUM_RD-1:0]        q_stall;
  logic [DATA_W-1:0]        debug_wb_pc;

  modport master (
    output flush, ms_to_ws_valid, in_pc, in_dest, in_we, in_wdata, in_exc, in_eret,
           rf_ready, q_raddr,
    input  ws_allowin, rf_we, rf_waddr, rf_wdata, send_flush, exc_eret, flush_pc,
           q_hit, q_data, q_stall, debug_wb_pc
  );

  modport slave (
    input  flush, ms_to_ws_valid, in_pc, in_dest, in_we, in_wdata, in_exc, in_eret,
           rf_ready, q_raddr,
    output ws_allowin, rf_we, rf_waddr, rf_wdata, send_flush, exc_eret, flush_pc,
           q_hit, q_data, q_stall, debug_wb_pc
  );
endinterface

// File: rtl/wb_commit_queue.sv
// In-order writeback commit queue with exception/eret flush and ID forwarding lookups.
// Optional WB_BYPASS_EN: an empty queue lets a ready result write the regfile with zero latency.
module wb_commit_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BE_W   = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NUM_RD = 2
) (
  input logic              clk,
  input logic              resetn,
  wb_commit_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] pc_q    [DEPTH];
  logic [ADDR_W-1:0] dest_q  [DEPTH];
  logic [BE_W-1:0]   we_q    [DEPTH];
  logic [DATA_W-1:0] wdata_q [DEPTH];
  logic              exc_q   [DEPTH];
  logic              eret_q  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic head_valid, head_xe, pop, push, bypass, allowin;

  assign head_valid = (count_q != '0);
  assign head_xe    = head_valid && (exc_q[head_q] || eret_q[head_q]);
  // Exc/eret and no-writeback heads retire without needing the regfile port.
  assign pop        = head_valid && (head_xe || (we_q[head_q] == '0) || bus.rf_ready);
  assign allowin    = (count_q < FULL_CNT) || pop;

`ifdef WB_BYPASS_EN
  assign bypass = !head_valid && bus.rf_ready && bus.ms_to_ws_valid && !bus.in_exc &&
                  !bus.in_eret && !bus.flush;
`else
  assign bypass = 1'b0;
`endif

  assign push = bus.ms_to_ws_valid && allowin && !bus.flush && !head_xe && !bypass;
  assign bus.ws_allowin = allowin;

  always_comb begin
    bus.rf_we       = '0;
    bus.rf_waddr    = '0;
    bus.rf_wdata    = '0;
    bus.debug_wb_pc = '0;
    bus.send_flush  = head_xe;
    bus.exc_eret    = 2'b00;
    bus.flush_pc    = '0;
    if (bypass) begin
      bus.rf_we       = bus.in_we;
      bus.rf_waddr    = bus.in_dest;
      bus.rf_wdata    = bus.in_wdata;
      bus.debug_wb_pc = bus.in_pc;
    end else if (head_valid) begin
      bus.rf_waddr = dest_q[head_q];
      bus.rf_wdata = wdata_q[head_q];
      if (!head_xe && bus.rf_ready) bus.rf_we = we_q[head_q];
      if (pop) bus.debug_wb_pc = pc_q[head_q];
      if (head_xe) begin
        bus.exc_eret = {exc_q[head_q], eret_q[head_q]};
        bus.flush_pc = pc_q[head_q];
      end
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(push);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (bus.flush || head_xe) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: every read is qualified by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail_q]    <= bus.in_pc;
      dest_q[tail_q]  <= bus.in_dest;
      we_q[tail_q]    <= bus.in_we;
      wdata_q[tail_q] <= bus.in_wdata;
      exc_q[tail_q]   <= bus.in_exc;
      eret_q[tail_q]  <= bus.in_eret;
    end
  end

  always_comb begin : lookup
    logic [ADDR_W-1:0] ra;
    logic [PTR_W-1:0]  idx;
    ra          = '0;
    idx         = '0;
    bus.q_hit   = '0;
    bus.q_stall = '0;
    bus.q_data  = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      ra = bus.q_raddr[p*ADDR_W +: ADDR_W];
      // Walk oldest to youngest so the youngest match is left standing.
      for (int unsigned k = 0; k < DEPTH; k++) begin
        idx = head_q + PTR_W'(k);
        if ((CNT_W'(k) < count_q) && (we_q[idx] != '0) && (dest_q[idx] == ra) &&
            (ra != '0)) begin
          bus.q_hit[p]                   = 1'b1;
          bus.q_data[p*DATA_W +: DATA_W] = wdata_q[idx];
          bus.q_stall[p]                 = !(&we_q[idx]) || exc_q[idx];
        end
      end
      if (bypass && (bus.in_we != '0) && (bus.in_dest == ra) && (ra != '0)) begin
        bus.q_hit[p]                   = 1'b1;
        bus.q_data[p*DATA_W +: DATA_W] = bus.in_wdata;
        bus.q_stall[p]                 = !(&bus.in_we);
      end
    end
  end
endmodule

// File: tb/tb_wb_commit_queue.sv
// Self-checking bench for wb_commit_queue: directed vector table, corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_wb_commit_queue;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned NUM_RD = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        exc;
    logic        eret;
  } ent_t;

  typedef struct packed {
    logic        fl;
    logic        v;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [3:0]  we;
    logic [31:0] wd;
    logic        ex;
    logic        er;
    logic        rr;
    logic        x_allow;
    logic [3:0]  x_we;
    logic [4:0]  x_waddr;
    logic [31:0] x_wdata;
    logic        x_sf;
    logic [1:0]  x_xe;
    logic [31:0] x_fpc;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  wb_commit_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BE_W(BE_W), .NUM_RD(NUM_RD)) bus ();

  wb_commit_queue #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BE_W(BE_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t mq[$];
  bit   nxt_clear, nxt_pop, nxt_push;
  ent_t nxt_ent;
  vec_t tbl[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit fl, input bit v, input logic [31:0] pc, input logic [4:0] d,
                       input logic [3:0] we, input logic [31:0] wd, input bit ex, input bit er,
                       input bit rr);
    bus.flush          = fl;
    bus.ms_to_ws_valid = v;
    bus.in_pc          = pc;
    bus.in_dest        = d;
    bus.in_we          = we;
    bus.in_wdata       = wd;
    bus.in_exc         = ex;
    bus.in_eret        = er;
    bus.rf_ready       = rr;
  endtask

  // Compare current outputs with the model and decide what the model does at the next edge.
  task automatic model_check();
    int          n;
    ent_t        h, inp, m;
    bit          xe, bp, pop, allow, hit, stall;
    logic [3:0]  exp_we;
    logic [31:0] dat;
    logic [4:0]  ra;
    #1;
    n   = mq.size();
    h   = (n > 0) ? mq[0] : '0;
    inp = '{pc: bus.in_pc, dest: bus.in_dest, we: bus.in_we, wdata: bus.in_wdata,
            exc: bus.in_exc, eret: bus.in_eret};
    bp  = 1'b0;
`ifdef WB_BYPASS_EN
    bp = (n == 0) && bus.rf_ready && bus.ms_to_ws_valid && !bus.in_exc && !bus.in_eret &&
         !bus.flush;
`endif
    xe     = (n > 0) && (h.exc || h.eret);
    pop    = (n > 0) && (xe || h.we == 4'h0 || bus.rf_ready);
    allow  = (n < int'(DEPTH)) || pop;
    exp_we = bp ? inp.we : ((n > 0) && !xe && bus.rf_ready) ? h.we : 4'h0;
    chk("rf_we", bus.rf_we, exp_we);
    if (exp_we != 4'h0) begin
      chk("rf_waddr", bus.rf_waddr, bp ? inp.dest : h.dest);
      chk("rf_wdata", bus.rf_wdata, bp ? inp.wdata : h.wdata);
    end
    chk("send_flush", bus.send_flush, xe);
    chk("exc_eret", bus.exc_eret, xe ? {h.exc, h.eret} : 2'b00);
    if (xe) chk("flush_pc", bus.flush_pc, h.pc);
    if (pop || bp) chk("debug_wb_pc", bus.debug_wb_pc, bp ? inp.pc : h.pc);
    chk("ws_allowin", bus.ws_allowin, allow);
    for (int p = 0; p < int'(NUM_RD); p++) begin
      ra    = bus.q_raddr[p*ADDR_W +: ADDR_W];
      hit   = 1'b0;
      stall = 1'b0;
      dat   = '0;
      for (int k = 0; k < n; k++) begin
        m = mq[k];
        if (m.we != 0 && m.dest == ra && ra != 0) begin
          hit = 1'b1; dat = m.wdata; stall = (m.we != 4'hF) || m.exc;
        end
      end
      if (bp && inp.we != 0 && inp.dest == ra && ra != 0) begin
        hit = 1'b1; dat = inp.wdata; stall = (inp.we != 4'hF);
      end
      chk("q_hit", bus.q_hit[p], hit);
      if (hit) begin
        chk("q_data", bus.q_data[p*DATA_W +: DATA_W], dat);
        chk("q_stall", bus.q_stall[p], stall);
      end
    end
    nxt_clear = bus.flush || xe;
    nxt_pop   = pop;
    nxt_push  = bus.ms_to_ws_valid && allow && !bus.flush && !xe && !bp;
    nxt_ent   = inp;
  endtask

  task automatic advance();
    @(posedge clk);
    if (nxt_clear) mq.delete();
    else begin
      if (nxt_pop) void'(mq.pop_front());
      if (nxt_push) mq.push_back(nxt_ent);
    end
    @(negedge clk);
  endtask

  task automatic step(input bit fl, input bit v, input logic [31:0] pc, input logic [4:0] d,
                      input logic [3:0] we, input logic [31:0] wd, input bit ex, input bit er,
                      input bit rr);
    drive(fl, v, pc, d, we, wd, ex, er, rr);
    model_check();
    advance();
  endtask

  initial begin
    //             fl v  pc            d  we    wd           ex er rr  al we    wa wdata     sf xe     fpc
    tbl[0]  = '{1'b0,1'b1,32'h1000,    5'd1,4'hF,32'h101,  1'b0,1'b0,1'b0, 1'b1,4'h0,5'd0,32'h0,   1'b0,2'b00,32'h0};
    tbl[1]  = '{1'b0,1'b1,32'h1004,    5'd2,4'hF,32'h102,  1'b0,1'b0,1'b0, 1'b1,4'h0,5'd0,32'h0,   1'b0,2'b00,32'h0};
    tbl[2]  = '{1'b0,1'b1,32'h1008,    5'd3,4'hF,32'h103,  1'b0,1'b0,1'b0, 1'b1,4'h0,5'd0,32'h0,   1'b0,2'b00,32'h0};
    tbl[3]  = '{1'b0,1'b1,32'h100C,    5'd4,4'hF,32'h104,  1'b0,1'b0,1'b0, 1'b1,4'h0,5'd0,32'h0,   1'b0,2'b00,32'h0};
    tbl[4]  = '{1'b0,1'b1,32'h1010,    5'd5,4'hF,32'h105,  1'b0,1'b0,1'b0, 1'b0,4'h0,5'd0,32'h0,   1'b0,2'b00,32'h0};
    tbl[5]  = '{1'b0,1'b1,32'h1010,    5'd5,4'hF,32'h105,  1'b0,1'b0,1'b1, 1'b1,4'hF,5'd1,32'h101, 1'b0,2'b00,32'h0};
    tbl[6]  = '{1'b0,1'b0,32'h0,       5'd0,4'h0,32'h0,    1'b0,1'b0,1'b1, 1'b1,4'hF,5'd2,32'h102, 1'b0,2'b00,32'h0};
    tbl[7]  = '{1'b0,1'b0,32'h0,       5'd0,4'h0,32'h0,    1'b0,1'b0,1'b1, 1'b1,4'hF,5'd3,32'h103, 1'b0,2'b00,32'h0};
    tbl[8]  = '{1'b0,1'b0,32'h0,       5'd0,4'h0,32'h0,    1'b0,1'b0,1'b1, 1'b1,4'hF,5'd4,32'h104, 1'b0,2'b00,32'h0};
    tbl[9]  = '{1'b0,1'b0,32'h0,       5'd0,4'h0,32'h0,    1'b0,1'b0,1'b1, 1'b1,4'hF,5'd5,32'h105, 1'b0,2'b00,32'h0};
    tbl[10] = '{1'b0,1'b0,32'h0,       5'd0,4'h0,32'h0,    1'b0,1'b0,1'b1, 1'b1,4'h0,5'd0,32'h0,   1'b0,2'b00,32'h0};
    tbl[11] = '{1'b0,1'b1,32'h100,     5'd2,4'hF,32'h11,   1'b0,1'b0,1'b0, 1'b1,4'h0,5'd0,32'h0,   1'b0,2'b00,32'h0};
    tbl[12] = '{1'b0,1'b1,32'hBFC00100,5'd4,4'hF,32'hDEAD, 1'b1,1'b0,1'b0, 1'b1,4'h0,5'd0,32'h0,   1'b0,2'b00,32'h0};
    tbl[13] = '{1'b0,1'b1,32'h108,     5'd3,4'hF,32'h33,   1'b0,1'b0,1'b0, 1'b1,4'h0,5'd0,32'h0,   1'b0,2'b00,32'h0};
    tbl[14] = '{1'b0,1'b0,32'h0,       5'd0,4'h0,32'h0,    1'b0,1'b0,1'b1, 1'b1,4'hF,5'd2,32'h11,  1'b0,2'b00,32'h0};
    tbl[15] = '{1'b0,1'b1,32'h10C,     5'd6,4'hF,32'h66,   1'b0,1'b0,1'b1, 1'b1,4'h0,5'd0,32'h0,   1'b1,2'b10,32'hBFC00100};
    tbl[16] = '{1'b0,1'b0,32'h0,       5'd0,4'h0,32'h0,    1'b0,1'b0,1'b1, 1'b1,4'h0,5'd0,32'h0,   1'b0,2'b00,32'h0};

    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    bus.q_raddr = '0;
    #3;
    chk("reset_rf_we", bus.rf_we, 4'h0);
    chk("reset_allowin", bus.ws_allowin, 1'b1);
    chk("reset_send_flush", bus.send_flush, 1'b0);
    chk("reset_exc_eret", bus.exc_eret, 2'b00);
    chk("reset_q_hit", bus.q_hit, 2'b00);
    chk("reset_q_stall", bus.q_stall, 2'b00);
    @(negedge clk);
    resetn = 1'b1;

    // Backpressure and exception sequence
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].fl, tbl[i].v, tbl[i].pc, tbl[i].dest, tbl[i].we, tbl[i].wd, tbl[i].ex,
            tbl[i].er, tbl[i].rr);
      model_check();
      chk($sformatf("tbl%0d_allowin", i), bus.ws_allowin, tbl[i].x_allow);
      chk($sformatf("tbl%0d_rf_we", i), bus.rf_we, tbl[i].x_we);
      if (tbl[i].x_we != 0) begin
        chk($sformatf("tbl%0d_waddr", i), bus.rf_waddr, tbl[i].x_waddr);
        chk($sformatf("tbl%0d_wdata", i), bus.rf_wdata, tbl[i].x_wdata);
      end
      chk($sformatf("tbl%0d_send_flush", i), bus.send_flush, tbl[i].x_sf);
      chk($sformatf("tbl%0d_exc_eret", i), bus.exc_eret, tbl[i].x_xe);
      if (tbl[i].x_sf) chk($sformatf("tbl%0d_flush_pc", i), bus.flush_pc, tbl[i].x_fpc);
      advance();
    end

    // Forwarding: youngest partial write wins and stalls
    step(1'b0, 1'b1, 32'h2000, 5'd5, 4'hF, 32'hAAAA0001, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h2004, 5'd5, 4'h1, 32'h000000BB, 1'b0, 1'b0, 1'b0);
    bus.q_raddr = {5'd0, 5'd5};
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    model_check();
    chk("fwd_hit", bus.q_hit, 2'b01);
    chk("fwd_data", bus.q_data[31:0], 32'h000000BB);
    chk("fwd_stall", bus.q_stall[0], 1'b1);
    advance();
    bus.q_raddr = '0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);

    // Flush with simultaneous push on a full queue
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 32'h3000 + 32'(i * 4), 5'(9 + i), 4'hF, 32'h900 + 32'(i), 1'b0, 1'b0,
           1'b0);
    drive(1'b1, 1'b1, 32'h3010, 5'd13, 4'hF, 32'hD13, 1'b0, 1'b0, 1'b1);
    model_check();
    chk("flush_head_we", bus.rf_we, 4'hF);
    chk("flush_head_waddr", bus.rf_waddr, 5'd9);
    advance();
    bus.q_raddr = {5'd0, 5'd13};
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    model_check();
    chk("flush_empty_we", bus.rf_we, 4'h0);
    chk("flush_dropped_hit", bus.q_hit, 2'b00);
    chk("flush_allowin", bus.ws_allowin, 1'b1);
    advance();

    // Reset mid-stream with three entries queued
    bus.q_raddr = {5'd0, 5'd1};
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'h4000 + 32'(i * 4), 5'(1 + i), 4'hF, 32'h40 + 32'(i), 1'b0, 1'b0,
           1'b0);
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    resetn = 1'b0;
    #1;
    chk("midrst_rf_we", bus.rf_we, 4'h0);
    chk("midrst_allowin", bus.ws_allowin, 1'b1);
    chk("midrst_q_hit", bus.q_hit, 2'b00);
    chk("midrst_send_flush", bus.send_flush, 1'b0);
    mq.delete();
    @(negedge clk);
    resetn = 1'b1;
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    bus.q_raddr = '0;

`ifdef WB_BYPASS_EN
    drive(1'b0, 1'b1, 32'h5000, 5'd7, 4'hF, 32'h7, 1'b0, 1'b0, 1'b1);
    model_check();
    chk("bypass_we", bus.rf_we, 4'hF);
    chk("bypass_waddr", bus.rf_waddr, 5'd7);
    advance();
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    model_check();
    chk("bypass_not_queued", bus.rf_we, 4'h0);
    advance();
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      logic [3:0] we;
      bit         ex, er, rr;
      case ($urandom % 4)
        0:       we = 4'h0;
        2:       we = 4'($urandom % 16);
        default: we = 4'hF;
      endcase
      ex = ($urandom % 16) == 0;
      er = !ex && (($urandom % 16) == 0);
      rr = ((c / 32) % 2 == 1) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
      bus.q_raddr = {5'($urandom % 8), 5'($urandom % 8)};
      step(($urandom % 24) == 0, ($urandom % 3) != 0, $urandom, 5'($urandom % 8), we, $urandom,
           ex, er, rr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
